// File: rtl/lii_out_arb_pack.sv
// lii_out_arb_pack: round-robin burst arbiter that packs NOUT kernel streams
// through a small FIFO onto a single LII phy output with src/dst tagging.
module lii_out_arb_pack #(
    parameter int         NOUT     = 4,
    parameter int         SW       = 16,
    parameter int         PW       = 64,
    parameter int         DEPTH    = 4,
    parameter int         BURST    = 4,
    parameter logic [7:0] SRC_ID   = 8'h00,
    parameter logic [7:0] DST_BASE = 8'h00
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic [NOUT*SW-1:0]       s_tdata,
    input  logic [NOUT-1:0]          s_tvalid,
    output logic [NOUT-1:0]          s_tready,
    output logic [PW-1:0]            lii_out_p0_tdata,
    output logic                     lii_out_p0_tvalid,
    input  logic                     lii_out_p0_tready,
    output logic [7:0]               lii_out_p0_src,
    output logic [7:0]               lii_out_p0_dst,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ce
);
    localparam int GW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 5;

    logic [GW-1:0] g;
    logic [GW-1:0] g_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [SW-1:0] data_mem [DEPTH];
    logic [7:0]    dst_mem  [DEPTH];
    logic          full;
    logic          push;
    logic          pop;
    logic          move;
    logic [SW-1:0] g_data;
    logic [7:0]    g_dst;

    // Ready depends only on registered occupancy, never on the phy ready.
    assign full   = (level == LW'(DEPTH));
    assign g_data = s_tdata[int'(g)*SW +: SW];
    assign g_dst  = DST_BASE + 8'(g);

    always_comb begin
        s_tready = '0;
        if (arstn && !full)
            s_tready[g] = 1'b1;
    end

    assign push = s_tvalid[g] & s_tready[g];
    assign pop  = lii_out_p0_tvalid & lii_out_p0_tready;

    // Grant moves on burst exhaustion or an idle granted stream; the nearest
    // valid stream after g wins, which gives round-robin fairness.
    always_comb begin
        g_nxt   = g;
        cnt_nxt = cnt;
        move    = 1'b0;
        if (push) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == CW'(BURST))
                move = 1'b1;
        end else if (!s_tvalid[g]) begin
            move = 1'b1;
        end
        if (move) begin
            cnt_nxt = '0;
            for (int k = NOUT - 1; k >= 1; k--) begin
                if (s_tvalid[(int'(g) + k) % NOUT])
                    g_nxt = GW'((int'(g) + k) % NOUT);
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            g     <= '0;
            cnt   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            g     <= g_nxt;
            cnt   <= cnt_nxt;
            level <= level + LW'(push) - LW'(pop);
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            data_mem[wptr] <= g_data;
            dst_mem[wptr]  <= g_dst;
        end
    end

    always_comb begin
        lii_out_p0_tdata         = '0;
        lii_out_p0_tdata[SW-1:0] = data_mem[rptr];
    end

    assign lii_out_p0_tvalid = (level != '0);
    assign lii_out_p0_dst    = dst_mem[rptr];
    assign lii_out_p0_src    = SRC_ID;
    assign ce                = !full | ~|s_tvalid;

endmodule
